seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
- Parametrised sequential shift-add multiplier: FSM controller and datapath in one block.
- Generalises the fixed-width unsigned multiplier controller to:
  - WIDTH-bit operands;
  - per-operation signed/unsigned mode;
  - a busy/done handshake;
  - a result register that holds its value across operations.
- Sits between operand-source logic and any consumer sampling product on done.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH), width of internal bit counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request; sampled only in IDLE; level-held protocol (see DONE).
sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
a  in  WIDTH  multiplicand; sampled in LOAD.
b  in  WIDTH  multiplier; sampled in LOAD.
busy  out  1  high in LOAD and CALC.
done  out  1  high in DONE only.
product  out  2*WIDTH  result register.

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk.
  - State -> IDLE.
  - busy=0, done=0, product=0.
  - All internal registers (acc, mcand, mplier, cnt, neg) -> 0.
- States: IDLE, LOAD, CALC, DONE (2-bit encoding; no unreachable codes; any illegal value -> IDLE).
- Transitions:
  - IDLE: start=1 -> LOAD; else stay.
  - LOAD: -> CALC (one cycle).
  - CALC: cnt==WIDTH-1 -> DONE; else stay.
  - DONE: start=1 -> stay; start=0 -> IDLE.
- LOAD actions (a, b, sgn captured at the edge leaving LOAD):
  - Operand conversion: if sgn=1, operands are converted to magnitudes, zero-extended to WIDTH+1 bits internally so -2^(WIDTH-1) is exact.
  - mcand <= |a| zero-extended to 2*WIDTH.
  - mplier <= |b|.
  - acc <= 0, cnt <= 0.
  - neg <= sgn & (a[MSB] ^ b[MSB]).
  - If sgn=0: magnitudes are the raw values and neg <= 0.
- CALC, per cycle:
  - If mplier[0]: acc <= acc + mcand (2*WIDTH modulo; cannot overflow for valid magnitudes).
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
- Entering DONE: product <= neg ? -acc_final : acc_final, where acc_final includes the last CALC addition.
- product changes only on entry to DONE; it holds through DONE, IDLE and subsequent LOAD/CALC until the next DONE entry.
- Latency: start=1 sampled at edge E0 -> LOAD at E0 -> DONE entered at edge E0+WIDTH+1.
  - done is visible for the cycle after that edge.
  - WIDTH=8: done high 10 edges after start sampled.
- start in LOAD/CALC is ignored; no abort except rst.
- a, b and sgn changes after LOAD have no effect.
- Reset mid-operation: the partial result is discarded and product returns to 0.
- Back-to-back: start held high through DONE keeps done=1 indefinitely.
  - A new operation requires start=0 for at least one cycle (DONE -> IDLE) and then start=1.
- Zero operands: normal full-length CALC; product=0.
- sgn=0 with a or b MSB set: treated as large unsigned value; neg=0.

Optional Feature:
SEQ_MULT_EARLY_EXIT_EN
- Defined:
  - CALC also exits to DONE when the next mplier value (mplier>>1) is zero.
  - LOAD goes directly to DONE when |b|==0, with product=0.
  - Latency becomes 2 + (index of highest set bit of |b|), minimum 1 cycle from LOAD.
  - Product values are identical to the non-early-exit build.
- Undefined: fixed WIDTH-cycle CALC, as above.

Test Plan:
1. WIDTH=8, sgn=0, a=13, b=11, start pulse -> busy for 9 cycles, done on the 10th edge after start sampled, product=0x008F; product holds after start=0 and the return to IDLE.
2. sgn=1, a=0xFD (-3), b=0x05 -> product=0xFFF1; sgn=1, a=0x80, b=0x80 -> product=0x4000; sgn=0, a=0xFF, b=0xFF -> product=0xFE01.
3. start held high through DONE -> done stays 1; a second start pulse while busy -> ignored, single result; start low for 1 cycle then high -> new operation begins, and the old product is visible until the new DONE.
4. Assert rst during CALC (cnt=4) -> immediately state IDLE, busy=0, done=0, product=0; next start completes normally with correct product.
5. Change a and b every cycle during CALC -> product matches the values captured in LOAD.
6. With SEQ_MULT_EARLY_EXIT_EN defined:
   - a=200, b=1 -> done 3 edges after start sampled, product=0x00C8.
   - b=0 -> DONE directly from LOAD, product=0.
   - Random sweep of a and b in both sgn modes -> products equal to the non-early-exit build.

Source files
------------

// File: rtl/seq_mult_unit_if.sv
// Operand/result handshake bundle for seq_mult_unit.
interface seq_mult_unit_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Operand source side
  modport master (
    output start, sgn, a, b,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, sgn, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier with signed/unsigned mode and busy/done handshake.
// Optional build macro: SEQ_MULT_EARLY_EXIT_EN (stop CALC once the remaining multiplier bits are zero).
module seq_mult_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  seq_mult_unit_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, mcand_q, product_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q, busy_q, done_q;

  logic [EW-1:0]    a_ext, b_ext;
  logic [WIDTH-1:0] a_mag, b_mag, mplier_shr;
  logic             neg_c;
  logic [PW-1:0]    acc_sum, product_d;
  logic             load_c, calc_c, done_entry_c;

  // Operand magnitudes: one extra bit so the most negative value converts exactly
  always_comb begin
    a_ext      = {bus.sgn & bus.a[WIDTH-1], bus.a};
    b_ext      = {bus.sgn & bus.b[WIDTH-1], bus.b};
    a_mag      = a_ext[WIDTH] ? WIDTH'(-a_ext) : bus.a;
    b_mag      = b_ext[WIDTH] ? WIDTH'(-b_ext) : bus.b;
    neg_c      = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_shr = mplier_q >> 1;
    product_d  = load_c ? '0 : (neg_q ? -acc_sum : acc_sum);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d      = state_q;
    load_c       = 1'b0;
    calc_c       = 1'b0;
    done_entry_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = CALC;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        if (b_mag == '0) begin
          state_d      = DONE;
          done_entry_c = 1'b1;
        end
`endif
      end
      CALC: begin
        calc_c = 1'b1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        if ((cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shr == '0)) begin
`else
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`endif
          state_d      = DONE;
          done_entry_c = 1'b1;
        end
      end
      DONE: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (load_c) begin
        acc_q    <= '0;
        mcand_q  <= PW'(a_mag);
        mplier_q <= b_mag;
        cnt_q    <= '0;
        neg_q    <= neg_c;
      end
      if (calc_c) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_shr;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (done_entry_c) product_q <= product_d;
    end
  end

  // Registered status flags, decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == LOAD) || (state_d == CALC);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit (WIDTH=8).
module tb_seq_mult_unit;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [2*WIDTH-1:0] sb_q[$];
  logic [2*WIDTH-1:0] last_exp;
  logic done_prev;

  seq_mult_unit_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference product and completion latency (edges from start sample to done visible)
  function automatic logic [2*WIDTH-1:0] model_prod(input logic [WIDTH-1:0] ia,
                                                     input logic [WIDTH-1:0] ib,
                                                     input logic is);
    int va, vb;
    va = is ? int'($signed(ia)) : int'(ia);
    vb = is ? int'($signed(ib)) : int'(ib);
    return (2*WIDTH)'(va * vb);
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] ib, input logic is);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int mb, hb;
    mb = (is && ib[WIDTH-1]) ? -int'($signed(ib)) : int'(ib);
    if (mb == 0) return 2;
    hb = 0;
    for (int i = 0; i < 31; i++) if (mb >= (1 << i)) hb = i;
    return 3 + hb;
`else
    return int'(WIDTH) + 2 + 0 * int'(ib) + 0 * int'(is);
`endif
  endfunction

  // Scoreboard: compare on each rising edge of done
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      if (sb_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else                  chk("product", 32'(bus.product), 32'(sb_q.pop_front()));
    end
    done_prev = bus.done;
  end

  task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic is,
                       input bit hold, input bit glitch, input bit scramble);
    int n, busy_n, lat;
    logic [2*WIDTH-1:0] exp;
    exp = model_prod(ia, ib, is);
    lat = model_lat(ib, is);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.sgn   = is;
    sb_q.push_back(exp);
    n = 0;
    busy_n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.busy) begin
        busy_n++;
        chk("product_hold", 32'(bus.product), 32'(last_exp));
      end
      if (!hold) bus.start = glitch && (n == 4);
      if (scramble && n >= 2) begin
        bus.a   = WIDTH'($urandom);
        bus.b   = WIDTH'($urandom);
        bus.sgn = 1'($urandom);
      end
    end while (!bus.done && n < 64);
    chk("latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(busy_n), 32'(lat - 1));
    last_exp = exp;
    if (!hold) begin
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_hold", 32'(bus.product), 32'(exp));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_exp  = '0;
    done_prev = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;

    // Basic unsigned, then signed corners and large unsigned
    do_op(8'd13, 8'd11, 1'b0, 0, 0, 0);
    chk("p_13x11", 32'(bus.product), 32'h008F);
    do_op(8'hFD, 8'h05, 1'b1, 0, 0, 0);
    chk("p_m3x5", 32'(bus.product), 32'hFFF1);
    do_op(8'h80, 8'h80, 1'b1, 0, 0, 0);
    chk("p_min_sq", 32'(bus.product), 32'h4000);
    do_op(8'hFF, 8'hFF, 1'b0, 0, 0, 0);
    chk("p_ff_sq", 32'(bus.product), 32'hFE01);
    do_op(8'h00, 8'h55, 1'b0, 0, 0, 0);
    do_op(8'h80, 8'hFF, 1'b1, 0, 0, 0);
    do_op(8'h7F, 8'h81, 1'b1, 0, 0, 0);

    // Start held through DONE keeps done asserted
    do_op(8'd7, 8'd9, 1'b0, 1, 0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("held_done", 32'(bus.done), 32'd1);
    end
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("held_release", 32'(bus.done), 32'd0);

    // Start pulse while busy is ignored; operands wiggling after LOAD are ignored
    do_op(8'd25, 8'd3, 1'b0, 0, 1, 0);
    do_op(8'hC3, 8'h9A, 1'b1, 0, 0, 1);
    do_op(8'd200, 8'd1, 1'b0, 0, 0, 0);
    chk("p_200x1", 32'(bus.product), 32'h00C8);
    do_op(8'd77, 8'd0, 1'b1, 0, 0, 0);

    // Reset during CALC with cnt=4
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd99;
    bus.b     = 8'hFF;
    bus.sgn   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;
    do_op(8'd19, 8'd21, 1'b0, 0, 0, 0);
    chk("p_after_rst", 32'(bus.product), 32'd399);

    // Random sweep in both modes
    for (int i = 0; i < 24; i++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'(i & 1), 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
